// File: rtl/mips_pkg.sv
// mips_pkg: load-type and write-back select codes shared by the MIPS pipeline stages
package mips_pkg;
    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LBU  = 3'd2;
    localparam logic [2:0] LOAD_LH   = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_LW   = 3'd5;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;
    localparam logic [1:0] WB_LUI    = 2'b11;
endpackage

// File: rtl/load_extender.sv
// load_extender: little-endian sub-word extraction, sign/zero extension and misalignment detection
module load_extender
    import mips_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] i_rdata,
    input  logic [1:0]       i_addr_low,
    input  logic [2:0]       i_load_type,
    output logic [NBITS-1:0] o_data,
    output logic             o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_half;
    assign w_byte    = i_rdata[{i_addr_low, 3'b000} +: 8];
    assign w_half    = i_addr_low[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_is_half = (i_load_type == LOAD_LH) || (i_load_type == LOAD_LHU);
    assign o_misaligned = (w_is_half && i_addr_low[0]) ||
                          ((i_load_type == LOAD_LW) && (i_addr_low != 2'b00));
    always_comb begin
        o_data = (i_load_type == LOAD_LB)  ? {{(NBITS-8){w_byte[7]}}, w_byte} :
                 (i_load_type == LOAD_LBU) ? {{(NBITS-8){1'b0}}, w_byte} :
                 (i_load_type == LOAD_LH)  ? {{(NBITS-16){w_half[15]}}, w_half} :
                 (i_load_type == LOAD_LHU) ? {{(NBITS-16){1'b0}}, w_half} :
                 i_rdata;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register feeding the 4-input write-back mux, with retire counter
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NREG_BITS = 5,
    parameter int CNT_BITS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [NBITS-1:0]     i_alu_result,
    input  logic [NBITS-1:0]     i_mem_rdata,
    input  logic [1:0]           i_addr_low,
    input  logic [2:0]           i_load_type,
    input  logic [NBITS-1:0]     i_link_addr,
    input  logic [NBITS-1:0]     i_upper_imm,
    input  logic [1:0]           i_wb_sel,
    input  logic                 i_reg_write,
    input  logic [NREG_BITS-1:0] i_rd,
    output logic [NBITS-1:0]     o_alu,
    output logic [NBITS-1:0]     o_mem,
    output logic [NBITS-1:0]     o_link,
    output logic [NBITS-1:0]     o_upper,
    output logic [1:0]           o_wb_sel,
    output logic                 o_reg_write,
    output logic [NREG_BITS-1:0] o_rd,
    output logic                 o_valid,
    output logic                 o_misaligned,
    output logic [CNT_BITS-1:0]  o_retired
);
    logic [NBITS-1:0]     w_ext;
    logic                 w_mis_raw;
    logic                 w_mis;
    logic                 w_we;
    logic [NBITS-1:0]     r_alu;
    logic [NBITS-1:0]     r_mem;
    logic [NBITS-1:0]     r_link;
    logic [NBITS-1:0]     r_upper;
    logic [1:0]           r_wb_sel;
    logic                 r_reg_write;
    logic [NREG_BITS-1:0] r_rd;
    logic                 r_valid;
    logic                 r_misaligned;
    logic [CNT_BITS-1:0]  r_retired;
    load_extender #(.NBITS(NBITS)) u_ext (
        .i_rdata      (i_mem_rdata),
        .i_addr_low   (i_addr_low),
        .i_load_type  (i_load_type),
        .o_data       (w_ext),
        .o_misaligned (w_mis_raw)
    );
    // A bubble never raises the misaligned flag; writes to $zero are dropped here.
    assign w_mis = i_valid & w_mis_raw;
    assign w_we  = i_reg_write & i_valid & ~w_mis & (i_rd != '0);
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_alu        <= '0;
            r_mem        <= '0;
            r_link       <= '0;
            r_upper      <= '0;
            r_wb_sel     <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_retired    <= '0;
        end else if (i_flush) begin
            r_alu        <= '0;
            r_mem        <= '0;
            r_link       <= '0;
            r_upper      <= '0;
            r_wb_sel     <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!i_stall) begin
            r_alu        <= i_alu_result;
            r_mem        <= w_ext;
            r_link       <= i_link_addr;
            r_upper      <= i_upper_imm;
            r_wb_sel     <= i_wb_sel;
            r_reg_write  <= w_we;
            r_rd         <= i_rd;
            r_valid      <= i_valid;
            r_misaligned <= w_mis;
            if (i_valid) r_retired <= r_retired + 1'b1;
        end
    end
    assign o_alu        = r_alu;
    assign o_mem        = r_mem;
    assign o_link       = r_link;
    assign o_upper      = r_upper;
    assign o_wb_sel     = r_wb_sel;
    assign o_reg_write  = r_reg_write;
    assign o_rd         = r_rd;
    assign o_valid      = r_valid;
    assign o_misaligned = r_misaligned;
    assign o_retired    = r_retired;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven checks of load extraction, write qualification, stall/flush/reset and counter wrap
module tb_mem_wb_stage;
    import mips_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid, reg_write;
    logic [31:0] alu, rdata, link, upper;
    logic [1:0]  addr_low, wb_sel;
    logic [2:0]  load_type;
    logic [4:0]  rd;
    logic [31:0] o_alu, o_mem, o_link, o_upper, o_retired;
    logic [1:0]  o_wb_sel;
    logic        o_reg_write, o_valid, o_misaligned;
    logic [4:0]  o_rd;
    logic [31:0] s_alu, s_mem, s_link, s_upper;
    logic [1:0]  s_wb_sel;
    logic        s_reg_write, s_valid, s_misaligned;
    logic [4:0]  s_rd;
    logic [3:0]  s_retired;
    int checks = 0, failures = 0;
    int cnt = 0;
    always #5 clk = ~clk;
    mem_wb_stage dut (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_alu_result(alu), .i_mem_rdata(rdata), .i_addr_low(addr_low), .i_load_type(load_type),
        .i_link_addr(link), .i_upper_imm(upper), .i_wb_sel(wb_sel), .i_reg_write(reg_write), .i_rd(rd),
        .o_alu(o_alu), .o_mem(o_mem), .o_link(o_link), .o_upper(o_upper), .o_wb_sel(o_wb_sel),
        .o_reg_write(o_reg_write), .o_rd(o_rd), .o_valid(o_valid), .o_misaligned(o_misaligned),
        .o_retired(o_retired)
    );
    mem_wb_stage #(.CNT_BITS(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_alu_result(alu), .i_mem_rdata(rdata), .i_addr_low(addr_low), .i_load_type(load_type),
        .i_link_addr(link), .i_upper_imm(upper), .i_wb_sel(wb_sel), .i_reg_write(reg_write), .i_rd(rd),
        .o_alu(s_alu), .o_mem(s_mem), .o_link(s_link), .o_upper(s_upper), .o_wb_sel(s_wb_sel),
        .o_reg_write(s_reg_write), .o_rd(s_rd), .o_valid(s_valid), .o_misaligned(s_misaligned),
        .o_retired(s_retired)
    );
    typedef struct {
        logic        valid;
        logic [2:0]  lt;
        logic [1:0]  al;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [1:0]  wb;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] exp_mem;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;
    vec_t v[11];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " alu"}, o_alu, 0);
        chk({tag, " mem"}, o_mem, 0);
        chk({tag, " link"}, o_link, 0);
        chk({tag, " upper"}, o_upper, 0);
        chk({tag, " ctl"}, {o_wb_sel, o_reg_write, o_rd, o_valid, o_misaligned}, 0);
    endtask
    task automatic drive(input logic vl, input logic [2:0] lt, input logic [1:0] al, input logic [31:0] rdat,
                         input logic [31:0] a, input logic [1:0] wb, input logic rw, input logic [4:0] r);
        valid = vl; load_type = lt; addr_low = al; rdata = rdat; alu = a;
        wb_sel = wb; reg_write = rw; rd = r;
        link = a ^ 32'h0000_1000; upper = {a[15:0], 16'h0};
    endtask
    initial begin
        v[0]  = '{1'b1, LOAD_LB,   2'd0, 32'h8040_20F0, 32'h11, WB_MEM,  1'b1, 5'd3,  32'hFFFF_FFF0, 1'b1, 1'b0};
        v[1]  = '{1'b1, LOAD_LHU,  2'd2, 32'h8040_20F0, 32'h22, WB_MEM,  1'b1, 5'd4,  32'h0000_8040, 1'b1, 1'b0};
        v[2]  = '{1'b1, LOAD_LH,   2'd2, 32'h8040_20F0, 32'h33, WB_MEM,  1'b1, 5'd4,  32'hFFFF_8040, 1'b1, 1'b0};
        v[3]  = '{1'b1, LOAD_LW,   2'd1, 32'h8040_20F0, 32'h44, WB_MEM,  1'b1, 5'd5,  32'h8040_20F0, 1'b0, 1'b1};
        v[4]  = '{1'b1, LOAD_NONE, 2'd0, 32'hCAFE_0001, 32'h1234, WB_ALU, 1'b1, 5'd0, 32'hCAFE_0001, 1'b0, 1'b0};
        v[5]  = '{1'b1, LOAD_LBU,  2'd3, 32'h8040_20F0, 32'h55, WB_MEM,  1'b1, 5'd31, 32'h0000_0080, 1'b1, 1'b0};
        v[6]  = '{1'b1, LOAD_LB,   2'd1, 32'h8040_20F0, 32'h66, WB_LINK, 1'b1, 5'd9,  32'h0000_0020, 1'b1, 1'b0};
        v[7]  = '{1'b1, LOAD_LH,   2'd1, 32'h8040_20F0, 32'h77, WB_MEM,  1'b1, 5'd10, 32'h0000_20F0, 1'b0, 1'b1};
        v[8]  = '{1'b0, LOAD_LH,   2'd3, 32'h8040_20F0, 32'h88, WB_MEM,  1'b1, 5'd11, 32'hFFFF_8040, 1'b0, 1'b0};
        v[9]  = '{1'b1, 3'd7,      2'd2, 32'hDEAD_BEEF, 32'h99, WB_LUI,  1'b0, 5'd12, 32'hDEAD_BEEF, 1'b0, 1'b0};
        v[10] = '{1'b1, LOAD_LW,   2'd0, 32'h1234_5678, 32'hAA, WB_MEM,  1'b1, 5'd1,  32'h1234_5678, 1'b1, 1'b0};
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, LOAD_LW, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, WB_LUI, 1'b1, 5'd31);
        tick();
        chk_zero("reset");
        chk("reset retired", o_retired, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(v[i].valid, v[i].lt, v[i].al, v[i].rdata, v[i].alu, v[i].wb, v[i].rw, v[i].rd);
            if (v[i].valid) cnt++;
            tick();
            chk($sformatf("v%0d mem", i), o_mem, v[i].exp_mem);
            chk($sformatf("v%0d we", i), {31'b0, o_reg_write}, {31'b0, v[i].exp_we});
            chk($sformatf("v%0d mis", i), {31'b0, o_misaligned}, {31'b0, v[i].exp_mis});
            chk($sformatf("v%0d valid", i), {31'b0, o_valid}, {31'b0, v[i].valid});
            chk($sformatf("v%0d alu", i), o_alu, v[i].alu);
            chk($sformatf("v%0d link", i), o_link, v[i].alu ^ 32'h0000_1000);
            chk($sformatf("v%0d upper", i), o_upper, {v[i].alu[15:0], 16'h0});
            chk($sformatf("v%0d sel_rd", i), {o_wb_sel, o_rd}, {v[i].wb, v[i].rd});
            chk($sformatf("v%0d retired", i), o_retired, cnt);
        end
        rst_n = 1'b0;
        tick();
        chk_zero("mid reset");
        chk("mid reset retired", o_retired, 0);
        rst_n = 1'b1;
        drive(1'b1, LOAD_LBU, 2'd1, 32'h0000_AB00, 32'h7070, WB_ALU, 1'b1, 5'd7);
        tick();
        chk("cap rd", {27'b0, o_rd}, 7);
        chk("cap mem", o_mem, 32'h0000_00AB);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, LOAD_LB, 2'(k), 32'h1357_9BDF + k, 32'h5000 + k, WB_LINK, 1'b1, 5'(20 + k));
            tick();
            chk($sformatf("stall%0d alu", k), o_alu, 32'h7070);
            chk($sformatf("stall%0d mem", k), o_mem, 32'h0000_00AB);
            chk($sformatf("stall%0d ctl", k), {o_wb_sel, o_reg_write, o_rd, o_valid}, {WB_ALU, 1'b1, 5'd7, 1'b1});
            chk($sformatf("stall%0d retired", k), o_retired, 1);
        end
        flush = 1'b1;
        tick();
        chk_zero("stall+flush");
        chk("stall+flush retired", o_retired, 1);
        flush = 1'b0; stall = 1'b0;
        drive(1'b1, LOAD_LW, 2'd0, 32'hA5A5_A5A5, 32'h1, WB_MEM, 1'b1, 5'd2);
        tick();
        chk("recapture mem", o_mem, 32'hA5A5_A5A5);
        stall = 1'b1; rst_n = 1'b0;
        tick();
        chk_zero("reset in stall");
        chk("reset in stall retired", o_retired, 0);
        stall = 1'b0; rst_n = 1'b1;
        drive(1'b1, LOAD_NONE, 2'd0, 32'h0, 32'h0, WB_ALU, 1'b0, 5'd0);
        for (int k = 0; k < 15; k++) tick();
        chk("wrap 15", {28'b0, s_retired}, 15);
        tick();
        chk("wrap 0", {28'b0, s_retired}, 0);
        tick();
        chk("wrap 1", {28'b0, s_retired}, 1);
        chk("wide no wrap", o_retired, 17);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
